dma_loader: RTL and testbench

DMA_LOADER -- requirements
Module: dma_loader

---
 rtl/dma_loader_if.sv | 37 +++
 rtl/dma_loader.sv | 109 ++++++++++
 tb/tb_dma_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_loader_if.sv
// dma_loader_if: burst-load control, upstream byte stream and memory write bus.
//   master : the side that issues bursts and supplies bytes (the bench or the system)
//   slave  : the loader itself
//   start/abort/base_addr/length      burst control
//   in_data/in_valid/in_ready         upstream byte handshake
//   address/data/write_signal         registered memory write port
//   read_signal                       memory read strobe, tied low
//   busy/done/checksum                status
interface dma_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       length;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              write_signal;
  logic              read_signal;
  logic              busy;
  logic              done;
  logic [15:0]       checksum;

  modport master (
    output start, abort, base_addr, length, in_data, in_valid,
    input  in_ready, address, data, write_signal, read_signal, busy, done, checksum
  );

  modport slave (
    input  start, abort, base_addr, length, in_data, in_valid,
    output in_ready, address, data, write_signal, read_signal, busy, done, checksum
  );
endinterface

// File: rtl/dma_loader.sv
// dma_loader: copies a burst of bytes from an upstream valid/ready stream into
// memory, starting at base_addr and writing one byte per accepted transfer.
// The running 16-bit checksum of accepted bytes is reported on completion.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : dma_loader_if.slave (control, upstream stream, memory write port, status)
module dma_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  dma_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Memory is 32 KiB: bit 15 of an incremented pointer is always cleared, so
  // 0x7FFF rolls over to 0x0000.
  localparam logic [ADDR_W-1:0] PTR_MASK = ~(ADDR_W'(1) << 15);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pointer;
  logic [15:0]       remaining;
  logic              accept;

  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              done_p1;
  logic [15:0]       cks_p1;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    ptr_inc = (p + ADDR_W'(1)) & PTR_MASK;
  endfunction

  function automatic logic [15:0] cks_add(input logic [15:0] s, input logic [DATA_W-1:0] b);
    cks_add = s + 16'(b);
  endfunction

  // Reset is folded in so no byte is offered during a reset cycle.
  assign bus.in_ready = (state == LOAD) && !bus.abort && !reset;
  assign accept       = bus.in_ready && bus.in_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.length == 16'd0) ? DONE : LOAD;
      end
      LOAD: begin
        if (bus.abort)                                state_nxt = IDLE;
        else if (accept && (remaining == 16'd1))      state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: accepted byte becomes a registered memory write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer   <= '0;
      remaining <= '0;
      addr_p1   <= '0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      done_p1   <= 1'b0;
      cks_p1    <= '0;
    end else begin
      vld_p1  <= accept;
      // An abort in DONE suppresses the completion pulse.
      done_p1 <= (state == DONE) && !bus.abort;
      if ((state == IDLE) && bus.start) begin
        cks_p1 <= '0;
        if (bus.length != 16'd0) begin
          pointer   <= bus.base_addr;
          remaining <= bus.length;
        end
      end
      if (accept) begin
        addr_p1   <= pointer;
        data_p1   <= bus.in_data;
        cks_p1    <= cks_add(cks_p1, bus.in_data);
        pointer   <= ptr_inc(pointer);
        remaining <= remaining - 16'd1;
      end
    end
  end

  assign bus.address      = addr_p1;
  assign bus.data         = data_p1;
  assign bus.write_signal = vld_p1;
  assign bus.read_signal  = 1'b0;
  assign bus.done         = done_p1;
  assign bus.checksum     = cks_p1;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_dma_loader.sv
module tb_dma_loader;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  dma_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed trace, gathered mid-cycle.
  logic [15:0] w_addr[$];
  logic [7:0]  w_data[$];
  int          w_cyc[$];
  int          acc_cyc[$];
  int          done_cyc[$];
  int          busy_cnt;

  always @(negedge clk) begin
    if (bus.write_signal === 1'b1) begin
      w_addr.push_back(bus.address);
      w_data.push_back(bus.data);
      w_cyc.push_back(cyc);
    end
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_cyc.push_back(cyc);
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
    if (bus.busy === 1'b1) busy_cnt++;
  end

  logic [7:0] stim_q[$];
  int         start_cyc;
  logic       abort_rdy;

  task automatic clear_mon();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    acc_cyc.delete(); done_cyc.delete(); busy_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one burst from stim_q. abort_after >= 0 raises abort together with
  // in_valid once that many bytes were accepted. hold_start keeps start high
  // until the last byte is accepted.
  task automatic drive_burst(input logic [15:0] base, input int len, input int gap_max,
                             input int abort_after, input bit hold_start);
    int  n;
    int  gap;
    int  guard;
    logic rdy;
    bus.base_addr = base;
    bus.length    = 16'(len);
    bus.start     = 1'b1;
    step();
    start_cyc = cyc;
    if (!hold_start) bus.start = 1'b0;
    n = 0;
    while (n < len) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      bus.in_valid = 1'b0;
      repeat (gap) step();
      bus.in_data  = stim_q[n];
      bus.in_valid = 1'b1;
      if (n == abort_after) begin
        bus.abort = 1'b1;
        #1 abort_rdy = bus.in_ready;
        step();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        break;
      end
      guard = 0;
      rdy   = 1'b0;
      while (rdy !== 1'b1 && guard < 50) begin
        #1 rdy = bus.in_ready;
        step();
        guard++;
      end
      if (rdy !== 1'b1) begin
        checks++;
        $display("FAIL accept_timeout: byte %0d not accepted within 50 cycles (in_ready=%b, want 1)", n, rdy);
        bus.in_valid = 1'b0;
        break;
      end
      n++;
      if (n == len) bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (bus.write_signal !== 1'b0) $display("FAIL reset_write got %b want 0", bus.write_signal); else passed++;
    checks++; if (bus.read_signal !== 1'b0) $display("FAIL reset_read got %b want 0", bus.read_signal); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.in_ready); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
    checks++; if (bus.address !== 16'h0 || bus.data !== 8'h0) $display("FAIL reset_addr_data got %h/%h want 0000/00", bus.address, bus.data); else passed++;
    checks++; if (bus.checksum !== 16'h0) $display("FAIL reset_checksum got %h want 0000", bus.checksum); else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    clear_mon();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_burst(16'h0100, 4, 0, -1, 1'b0);
    checks++; if (w_addr.size() !== 4) $display("FAIL basic_nwrites got %0d want 4", w_addr.size()); else passed++;
    for (int i = 0; i < 4 && i < w_addr.size(); i++) begin
      checks++;
      if (w_addr[i] !== 16'(16'h0100 + i) || w_data[i] !== stim_q[i] || w_cyc[i] !== start_cyc + 1 + i)
        $display("FAIL basic_write%0d got %h/%h@%0d want %h/%h@%0d", i, w_addr[i], w_data[i], w_cyc[i],
                 16'(16'h0100 + i), stim_q[i], start_cyc + 1 + i);
      else passed++;
    end
    checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== start_cyc + 5)
      $display("FAIL basic_done got %0d pulses first@%0d want 1@%0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1, start_cyc + 5);
    else passed++;
    checks++; if (bus.checksum !== 16'h00AA) $display("FAIL basic_checksum got %h want 00aa", bus.checksum); else passed++;
    checks++; if (busy_cnt !== 5) $display("FAIL basic_busy got %0d cycles want 5", busy_cnt); else passed++;
  endtask

  task automatic test_gaps();
    int          len;
    logic [15:0] base;
    logic [15:0] addr;
    logic [15:0] sum;
    for (int b = 0; b < 4; b++) begin
      len  = int'($urandom_range(8, 1));
      base = 16'($urandom);
      clear_mon();
      stim_q.delete();
      for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom));
      drive_burst(base, len, 3, -1, 1'b0);
      checks++;
      if (w_addr.size() !== len || acc_cyc.size() !== len)
        $display("FAIL gaps_count got %0d writes %0d accepts want %0d", w_addr.size(), acc_cyc.size(), len);
      else passed++;
      sum  = 16'h0;
      addr = base;
      for (int i = 0; i < len; i++) begin
        sum = sum + 16'(stim_q[i]);
        if (i < w_addr.size() && i < acc_cyc.size()) begin
          checks++;
          if (w_addr[i] !== addr || w_data[i] !== stim_q[i] || w_cyc[i] !== acc_cyc[i] + 1)
            $display("FAIL gaps_write%0d got %h/%h@%0d want %h/%h@%0d", i, w_addr[i], w_data[i], w_cyc[i],
                     addr, stim_q[i], acc_cyc[i] + 1);
          else passed++;
        end
        addr = (addr + 16'd1) & 16'h7FFF;
      end
      if (acc_cyc.size() == len) begin
        checks++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== acc_cyc[len-1] + 2)
          $display("FAIL gaps_done got %0d pulses want 1@%0d", done_cyc.size(), acc_cyc[len-1] + 2);
        else passed++;
      end
      checks++; if (bus.checksum !== sum) $display("FAIL gaps_checksum got %h want %h", bus.checksum, sum); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a[3];
    exp_a = '{16'h7FFE, 16'h7FFF, 16'h0000};
    clear_mon();
    stim_q = '{8'h01, 8'h02, 8'h03};
    drive_burst(16'h7FFE, 3, 1, -1, 1'b0);
    checks++; if (w_addr.size() !== 3) $display("FAIL wrap_nwrites got %0d want 3", w_addr.size()); else passed++;
    for (int i = 0; i < 3 && i < w_addr.size(); i++) begin
      checks++;
      if (w_addr[i] !== exp_a[i]) $display("FAIL wrap_addr%0d got %h want %h", i, w_addr[i], exp_a[i]);
      else passed++;
    end
    checks++; if (bus.checksum !== 16'h0006) $display("FAIL wrap_checksum got %h want 0006", bus.checksum); else passed++;
  endtask

  task automatic test_zero_len();
    clear_mon();
    stim_q.delete();
    drive_burst(16'h1234, 0, 0, -1, 1'b0);
    checks++; if (w_addr.size() !== 0) $display("FAIL zero_writes got %0d want 0", w_addr.size()); else passed++;
    checks++; if (busy_cnt !== 1) $display("FAIL zero_busy got %0d cycles want 1", busy_cnt); else passed++;
    checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== start_cyc + 1)
      $display("FAIL zero_done got %0d pulses want 1@%0d", done_cyc.size(), start_cyc + 1);
    else passed++;
    checks++; if (bus.checksum !== 16'h0) $display("FAIL zero_checksum got %h want 0000", bus.checksum); else passed++;
  endtask

  task automatic test_abort();
    clear_mon();
    stim_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    abort_rdy = 1'bx;
    drive_burst(16'h0500, 5, 0, 2, 1'b0);
    checks++; if (w_addr.size() !== 2) $display("FAIL abort_nwrites got %0d want 2", w_addr.size()); else passed++;
    for (int i = 0; i < 2 && i < w_addr.size(); i++) begin
      checks++;
      if (w_addr[i] !== 16'(16'h0500 + i) || w_data[i] !== stim_q[i])
        $display("FAIL abort_write%0d got %h/%h want %h/%h", i, w_addr[i], w_data[i], 16'(16'h0500 + i), stim_q[i]);
      else passed++;
    end
    checks++; if (abort_rdy !== 1'b0) $display("FAIL abort_ready got %b want 0", abort_rdy); else passed++;
    checks++; if (done_cyc.size() !== 0) $display("FAIL abort_done got %0d pulses want 0", done_cyc.size()); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL abort_idle busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.checksum !== 16'h0153) $display("FAIL abort_checksum got %h want 0153", bus.checksum); else passed++;
    // A fresh burst after the abort behaves normally.
    clear_mon();
    stim_q = '{8'h10, 8'h20, 8'h30};
    drive_burst(16'h0300, 3, 0, -1, 1'b0);
    checks++; if (w_addr.size() !== 3) $display("FAIL abort_next_nwrites got %0d want 3", w_addr.size()); else passed++;
    checks++; if (done_cyc.size() !== 1) $display("FAIL abort_next_done got %0d pulses want 1", done_cyc.size()); else passed++;
    checks++; if (bus.checksum !== 16'h0060) $display("FAIL abort_next_checksum got %h want 0060", bus.checksum); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    bus.base_addr = 16'h0200;
    bus.length    = 16'd6;
    bus.start     = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.in_data  = 8'h5A;
    bus.in_valid = 1'b1;
    step(); step();
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL rstmid_ready got %b want 0", bus.in_ready); else passed++;
    step();
    checks++;
    if (bus.write_signal !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.read_signal !== 1'b0)
      $display("FAIL rstmid_ctrl got w%b b%b d%b r%b want all 0", bus.write_signal, bus.busy, bus.done, bus.read_signal);
    else passed++;
    checks++;
    if (bus.address !== 16'h0 || bus.data !== 8'h0 || bus.checksum !== 16'h0)
      $display("FAIL rstmid_data got %h/%h/%h want 0000/00/0000", bus.address, bus.data, bus.checksum);
    else passed++;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    step();
    // start held high all through LOAD must not restart the burst.
    clear_mon();
    stim_q = '{8'h07, 8'h08, 8'h09};
    drive_burst(16'h0400, 3, 1, -1, 1'b1);
    checks++; if (w_addr.size() !== 3) $display("FAIL hold_nwrites got %0d want 3", w_addr.size()); else passed++;
    for (int i = 0; i < 3 && i < w_addr.size(); i++) begin
      checks++;
      if (w_addr[i] !== 16'(16'h0400 + i)) $display("FAIL hold_addr%0d got %h want %h", i, w_addr[i], 16'(16'h0400 + i));
      else passed++;
    end
    checks++; if (done_cyc.size() !== 1) $display("FAIL hold_done got %0d pulses want 1", done_cyc.size()); else passed++;
    checks++; if (bus.checksum !== 16'h0018) $display("FAIL hold_checksum got %h want 0018", bus.checksum); else passed++;
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    busy_cnt      = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_zero_len();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
